wide_add_sequencer: RTL and testbench

Multi-word sequential adder that issues a wide addition to a single `PPA_Kogge_Stone_24bit` instance one WIDTH-bit slice per cycle. It chains each slice's carry-out into the next slice's carry-in. The block sits directly in front of the Kogge-Stone adder: it feeds the adder's A/B/cin and consumes its S/cout. Upstream sees a valid/ready operand port and downstream sees a valid/ready result port.

---
 rtl/wide_add_pkg.sv | 13 +
 rtl/PPA_Kogge_Stone_24bit.sv | 37 +++
 rtl/wide_add_sequencer.sv | 111 +++++++++++
 tb/tb_wide_add_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and default sizing for the wide sequential adder.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 24;
  localparam int DEFAULT_WORDS = 3;

endpackage

// File: rtl/PPA_Kogge_Stone_24bit.sv
// Combinational Kogge-Stone parallel-prefix adder, S/cout = A + B + cin.
// Zero latency; no flow control.
// Not applicable: purely combinational, no backpressure.
module PPA_Kogge_Stone_24bit #(
  parameter int width = 24
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             cin,
  output logic [width-1:0] S,
  output logic             cout
);

  localparam int LV = (width > 1) ? $clog2(width) : 0;

  logic [width-1:0] gl [0:LV];
  logic [width-1:0] pl [0:LV];
  logic [width-1:0] c;
  logic [width:0]   cv;

  assign gl[0] = A & B;
  assign pl[0] = A ^ B;

  // Each level doubles the span of every group generate/propagate term.
  for (genvar l = 1; l <= LV; l++) begin : g_level
    localparam int DIST = 1 << (l - 1);
    localparam logic [width-1:0] LOW_MASK = {width{1'b1}} >> (width - DIST);
    assign gl[l] = gl[l-1] | (pl[l-1] & (gl[l-1] << DIST));
    assign pl[l] = pl[l-1] & ((pl[l-1] << DIST) | LOW_MASK);
  end

  assign c    = gl[LV] | (pl[LV] & {width{cin}});
  assign cv   = {c, cin};
  assign S    = pl[0] ^ cv[width-1:0];
  assign cout = cv[width];

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add (optional subtract with WIDE_ADD_SUB_EN) issued one WIDTH-bit slice per cycle through one adder.
// Latency: accept edge + WORDS cycles to out_valid; one result per WORDS+2 cycles back-to-back.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE, no queuing.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout
);

  localparam int N  = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t         state;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   sum_reg;
  logic           cin_reg;
  logic           carry;
  logic           cout_reg;
  logic [IW-1:0]  idx;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cin;
  logic             add_cout;

  always_comb begin
    add_a   = a_reg[idx*WIDTH +: WIDTH];
    add_b   = b_reg[idx*WIDTH +: WIDTH];
    add_cin = (idx == '0) ? cin_reg : carry;
  end

  PPA_Kogge_Stone_24bit #(.width(WIDTH)) u_adder (
    .A    (add_a),
    .B    (add_b),
    .cin  (add_cin),
    .S    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cin_reg  <= 1'b0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
`ifdef WIDE_ADD_SUB_EN
            // Subtract is A + ~B + 1; inverting B once here keeps the slice path identical.
            b_reg   <= in_sub ? ~in_b : in_b;
            cin_reg <= in_sub | in_cin;
`else
            b_reg   <= in_b;
            cin_reg <= in_cin;
`endif
            idx     <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx*WIDTH +: WIDTH] <= add_s;
          carry <= add_cout;
          if (idx == LAST) begin
            cout_reg <= add_cout;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboarded bench for wide_add_sequencer (WIDTH=24, WORDS=3); subtract cases built with WIDE_ADD_SUB_EN.
module tb_wide_add_sequencer;

  localparam int WIDTH = 24;
  localparam int WORDS = 3;
  localparam int N     = WIDTH * WORDS;
  localparam logic [N:0] TWO_N = {1'b1, {N{1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
`ifdef WIDE_ADD_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         in_ready;
  logic         out_valid;
  logic         out_cout;
  logic [N-1:0] out_sum;

  int tests = 0;
  int fails = 0;
  int ready_mode = 1;   // 0 low, 1 high, 2 random stalls
  logic [N:0] exp_q[$];

  always #5 clk = ~clk;

  wide_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef WIDE_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  // Golden result: plain integer arithmetic over N+1 bits.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + TWO_N - {1'b0, b};
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  endfunction

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pop and compare on every output handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h required no output", {out_cout, out_sum});
      end else begin
        check("result", {out_cout, out_sum}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic sub);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout("send_wait_ready");
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef WIDE_ADD_SUB_EN
    in_sub   = sub;
`endif
    @(posedge clk);
    exp_q.push_back(model(a, b, cin, sub));
    #1;
    in_valid = 1'b0;
    in_a     = N'({$urandom(), $urandom(), $urandom()});
    in_b     = N'({$urandom(), $urandom(), $urandom()});
    in_cin   = 1'($urandom());
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || !in_ready) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, in_ready=%b", exp_q.size(), in_ready);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a1, b1;
    logic [N:0]   exp1;
    logic         sub_r;
    int           n;
    bit           seen;

    // Reset state
    #12;
    check("reset_in_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, 1'b1});
    check("reset_out_valid", {{N{1'b0}}, out_valid}, '0);
    check("reset_out_sum", {1'b0, out_sum}, '0);
    check("reset_out_cout", {{N{1'b0}}, out_cout}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;

    // Full carry ripple and latency
    send({N{1'b1}}, '0, 1'b1, 1'b0);
    n = 0;
    seen = 0;
    while (!seen && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) timeout("ripple_valid");
    else check("ripple_latency", (N+1)'(n), (N+1)'(WORDS));
    wait_idle();

    // Inter-slice carry
    send(72'h000000_000000_FFFFFF, 72'd1, 1'b0, 1'b0);
    wait_idle();

    // Back-pressure with in_valid held high throughout
    ready_mode = 0;
    @(posedge clk);
    #2;
    a1 = N'({$urandom(), $urandom(), $urandom()});
    b1 = N'({$urandom(), $urandom(), $urandom()});
    exp1 = model(a1, b1, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a1;
    in_b = b1;
    in_cin = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp1);
    #1;
    a1 = 72'h123456_789ABC_DEF012;
    b1 = 72'h0F0F0F_F0F0F0_333333;
    in_a = a1;
    in_b = b1;
    in_cin = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("stall_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_out_valid", {{N{1'b0}}, out_valid}, {{N{1'b0}}, 1'b1});
      check("stall_result", {out_cout, out_sum}, exp1);
      check("stall_in_ready", {{N{1'b0}}, in_ready}, '0);
    end
    ready_mode = 1;
    exp_q.push_back(model(a1, b1, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("post_handshake_in_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, 1'b1});
    check("post_handshake_out_valid", {{N{1'b0}}, out_valid}, '0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset during slice 1
    send(72'hABCDEF_ABCDEF_ABCDEF, 72'h111111_111111_111111, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_out_valid", {{N{1'b0}}, out_valid}, '0);
    check("abort_out_sum", {1'b0, out_sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {{N{1'b0}}, in_ready}, {{N{1'b0}}, 1'b1});
    send(72'h800000_000000_000001, 72'h800000_000000_FFFFFF, 1'b1, 1'b0);
    wait_idle();

`ifdef WIDE_ADD_SUB_EN
    send(72'd5, 72'd7, 1'b0, 1'b1);
    wait_idle();
    send(72'd7, 72'd5, 1'b0, 1'b1);
    wait_idle();
`endif

    // Random regression with random out_ready stalls
    ready_mode = 2;
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef WIDE_ADD_SUB_EN
      sub_r = 1'($urandom());
`else
      sub_r = 1'b0;
`endif
      send(N'({$urandom(), $urandom(), $urandom()}),
           N'({$urandom(), $urandom(), $urandom()}),
           1'($urandom()), sub_r);
    end
    wait_idle();
    ready_mode = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
